// File: rtl/encoder_pkg.sv
// Shared widths and state naming for the 64-to-6 streaming encoder.
package encoder_pkg;

  localparam int unsigned VEC_W = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned GRP_W = 8;
  localparam int unsigned SUB_W = 3;

  // Drain state is implied by the pending vector: nothing pending means idle.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/encoder_8x3.sv
// 8-to-3 priority encoder; lowest set bit wins unless MSB_FIRST selects highest.
module encoder_8x3
  import encoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [GRP_W-1:0] d,
  output logic [SUB_W-1:0] q,
  output logic             v
);

  // Scan so that the winning bit is written last; q stays 0 when nothing is set.
  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < GRP_W; i++) begin
      if (MSB_FIRST) begin
        if (d[i]) q = SUB_W'(i);
      end else begin
        if (d[GRP_W-1-i]) q = SUB_W'(GRP_W-1-i);
      end
    end
  end

  assign v = |d;

endmodule

// File: rtl/encoder_64x6_stream.sv
// Streaming 64-to-6 encoder: emits the index of every set bit of an accepted
// vector, one per output handshake, in priority order.
module encoder_64x6_stream
  import encoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_drop
);

  logic [VEC_W-1:0] pend_q, pend_d;
  logic             zero_drop_q, zero_drop_d;
  logic [GRP_W-1:0] gv;
  logic [GRP_W-1:0] grp_bits;
  logic [SUB_W-1:0] grp, sub;
  logic             grp_v, sub_v;
  state_e           state;

  // Level 1 input: one flag per byte of the pending vector.
  always_comb begin
    gv = '0;
    for (int unsigned g = 0; g < GRP_W; g++) begin
      gv[g] = |pend_q[g*GRP_W +: GRP_W];
    end
  end

  encoder_8x3 #(.MSB_FIRST(MSB_FIRST)) u_grp (
    .d (gv),
    .q (grp),
    .v (grp_v)
  );

  assign grp_bits = pend_q[{grp, 3'b000} +: GRP_W];

  encoder_8x3 #(.MSB_FIRST(MSB_FIRST)) u_sub (
    .d (grp_bits),
    .q (sub),
    .v (sub_v)
  );

  // sub_v always follows grp_v; combining them keeps the level-2 flag in use.
  assign state     = (grp_v && sub_v) ? ST_DRAIN : ST_IDLE;
  assign out_valid = (state == ST_DRAIN);
  assign out_idx   = {grp, sub};
  assign out_last  = out_valid && ((pend_q & (pend_q - VEC_W'(1))) == '0);
  assign in_ready  = !out_valid || (out_valid && out_ready && out_last);
  assign zero_drop = zero_drop_q;

  // Next pending vector: clear the emitted bit, then let a new vector override.
  always_comb begin
    pend_d      = pend_q;
    zero_drop_d = 1'b0;
    if (out_valid && out_ready) begin
      pend_d[out_idx] = 1'b0;
    end
    if (in_valid && in_ready) begin
      pend_d      = in_vec;
      zero_drop_d = (in_vec == '0);
    end
  end

  // Pending vector and zero-drop pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule

// File: tb/tb_encoder_64x6_stream.sv
// Scoreboard bench: one DUT per priority order, driven by shared stimulus.
module tb_encoder_64x6_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_vec;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, out_last0, zero_drop0;
  logic [5:0]  out_idx0;
  logic        in_ready1, out_valid1, out_last1, zero_drop1;
  logic [5:0]  out_idx1;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  acc_cnt = 0;
  int  rdy_mode = 0;
  bit  en = 1'b0;
  bit  ready_ok = 1'b1;
  bit  exp_zero = 1'b0;
  int  q0[$];
  int  q1[$];

  encoder_64x6_stream #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
    .out_last(out_last0), .zero_drop(zero_drop0)
  );

  encoder_64x6_stream #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
    .out_last(out_last1), .zero_drop(zero_drop1)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Consumer: out_ready pattern selected by rdy_mode (1, toggle, random, 0).
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model: on acceptance, queue every set index in each priority order.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_zero = 1'b0;
    end else begin
      exp_zero = 1'b0;
      if (in_valid && ready_ok) begin
        acc_cnt++;
        exp_zero = (in_vec == 64'd0);
        for (int i = 0; i < 64; i++) if (in_vec[i]) q0.push_back(i);
        for (int i = 63; i >= 0; i--) if (in_vec[i]) q1.push_back(i);
      end
    end
  end

  // Monitor: compare presented outputs against queue fronts, pop on handshake.
  always @(negedge clk) begin
    ready_ok = (q0.size() == 0) || (out_ready && q0.size() == 1);
    if (en) begin
      chk("in_ready_lsb", {63'd0, in_ready0}, {63'd0, ready_ok});
      chk("in_ready_msb", {63'd0, in_ready1}, {63'd0, ready_ok});
      chk("zero_drop_lsb", {63'd0, zero_drop0}, {63'd0, exp_zero});
      chk("zero_drop_msb", {63'd0, zero_drop1}, {63'd0, exp_zero});
      chk("out_valid_lsb", {63'd0, out_valid0}, {63'd0, q0.size() != 0});
      chk("out_valid_msb", {63'd0, out_valid1}, {63'd0, q1.size() != 0});
      if (q0.size() != 0) begin
        chk("out_idx_lsb", {58'd0, out_idx0}, 64'(q0[0]));
        chk("out_last_lsb", {63'd0, out_last0}, {63'd0, q0.size() == 1});
      end else begin
        chk("idle_idx_lsb", {58'd0, out_idx0}, 64'd0);
        chk("idle_last_lsb", {63'd0, out_last0}, 64'd0);
      end
      if (q1.size() != 0) begin
        chk("out_idx_msb", {58'd0, out_idx1}, 64'(q1[0]));
        chk("out_last_msb", {63'd0, out_last1}, {63'd0, q1.size() == 1});
      end else begin
        chk("idle_idx_msb", {58'd0, out_idx1}, 64'd0);
        chk("idle_last_msb", {63'd0, out_last1}, 64'd0);
      end
    end
    if (out_ready && q0.size() != 0) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
  end

  task automatic send(input logic [63:0] v);
    int start;
    bit got;
    start    = acc_cnt;
    got      = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: vector %0h not accepted, required acceptance", v);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (q0.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d indices still pending, required 0", q0.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] v;
    int kind;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_vec   = '0;
    @(posedge clk);
    #1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Two extreme bits, full-rate consumer.
    rdy_mode = 0;
    send(64'h8000_0000_0000_0001);
    drain();

    // All ones: 64 beats in each order.
    send('1);
    drain();

    // Stalling consumer.
    rdy_mode = 1;
    send(64'h0000_0100_0000_0010);
    drain();

    // Back-to-back single-bit vectors with in_valid held.
    rdy_mode = 0;
    idle(1);
    send(64'h1);
    send(64'h4);
    drain();

    // Single bit 63.
    send(64'h8000_0000_0000_0000);
    drain();

    // All-zero vector.
    send(64'h0);
    idle(3);

    // Reset mid-drain after the first beat.
    send(64'hFF00);
    @(posedge clk);
    #1;
    rdy_mode = 3;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    idle(3);

    // Randomised vectors, gaps, consumer patterns and occasional resets.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(9));
      v    = '0;
      case (kind)
        0: v = '0;
        1: v = '1;
        2, 3, 4, 5: repeat ($urandom_range(1, 4)) v[$urandom_range(63)] = 1'b1;
        default: v = {$urandom, $urandom};
      endcase
      rdy_mode = ($urandom_range(1) == 0) ? 0 : 2;
      idle(int'($urandom_range(2)));
      send(v);
      if ($urandom_range(15) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    rdy_mode = 0;
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
